turnstile_input_conditioner: RTL and testbench

Front-end stage that sits directly upstream of the turnstile FSM. It takes the raw, asynchronous coin-sensor and push-arm switch signals and conditions each one: 2-FF synchroniser, counter-based debounce, then rising-edge detection. It produces clean single-cycle o_coin / o_push pulses plus debounced levels for the turnstile core, which consumes them as its i_coin / i_push inputs.

---
 rtl/turnstile_input_conditioner.sv | 136 +++++++++++++
 tb/tb_turnstile_input_conditioner.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/turnstile_input_conditioner.sv
// Sync + debounce + rising-edge pulse for the turnstile coin/push inputs.
// Optional coin-credit mode selected by TURNSTILE_COIN_CREDIT_EN.

module turnstile_debounce_chan #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_pulse,
  output logic o_level
);
  typedef enum logic [1:0] {S_LOW, S_RISE_CHK, S_HIGH, S_FALL_CHK} state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_pulse;
  logic             w_sync;

  assign w_sync  = r_sync[1];
  assign o_pulse = r_pulse;
  assign o_level = r_level;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sync  <= '0;
      r_state <= S_LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_raw};
      r_pulse <= 1'b0;
      case (r_state)
        S_LOW: if (w_sync) begin
          r_state <= S_RISE_CHK;
          r_cnt   <= '0;
        end
        S_RISE_CHK: begin
          if (!w_sync) begin
            r_state <= S_LOW;
          end else if (r_cnt == LP_LAST) begin
            r_state <= S_HIGH;
            r_level <= 1'b1;
            r_pulse <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HIGH: if (!w_sync) begin
          r_state <= S_FALL_CHK;
          r_cnt   <= '0;
        end
        S_FALL_CHK: begin
          // falling edge is debounced the same way but never pulses
          if (w_sync) begin
            r_state <= S_HIGH;
          end else if (r_cnt == LP_LAST) begin
            r_state <= S_LOW;
            r_level <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_LOW;
      endcase
    end
  end
endmodule

module turnstile_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_coin_raw,
  input  logic       i_push_raw,
  output logic       o_coin,
  output logic       o_push,
  output logic       o_coin_level,
  output logic       o_push_level,
  output logic [2:0] o_credit
);
  // channel 0 = coin, channel 1 = push
  logic [1:0] w_raw;
  logic [1:0] w_pulse;
  logic [1:0] w_level;

  assign w_raw = {i_push_raw, i_coin_raw};

  for (genvar g = 0; g < 2; g++) begin : g_chan
    turnstile_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_chan (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .i_raw  (w_raw[g]),
      .o_pulse(w_pulse[g]),
      .o_level(w_level[g])
    );
  end

  assign o_push       = w_pulse[1];
  assign o_coin_level = w_level[0];
  assign o_push_level = w_level[1];

`ifdef TURNSTILE_COIN_CREDIT_EN
  logic [2:0] r_credit;

  // simultaneous coin and push pulses cancel out
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_credit <= 3'd0;
    end else begin
      case (w_pulse)
        2'b01:   if (r_credit != 3'd7) r_credit <= r_credit + 3'd1;
        2'b10:   if (r_credit != 3'd0) r_credit <= r_credit - 3'd1;
        default: r_credit <= r_credit;
      endcase
    end
  end

  assign o_credit = r_credit;
  assign o_coin   = |r_credit;
`else
  assign o_credit = 3'd0;
  assign o_coin   = w_pulse[0];
`endif
endmodule

// File: tb/tb_turnstile_input_conditioner.sv
// Bench for turnstile_input_conditioner: directed vector table, reset-abort
// sequence, credit sequence (when enabled) and random stimulus vs a run-length model.
module tb_turnstile_input_conditioner;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_coin_raw, i_push_raw;
  logic       o_coin, o_push, o_coin_level, o_push_level;
  logic [2:0] o_credit;

  int n_vec = 0;
  int n_err = 0;

  turnstile_input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_coin_raw  (i_coin_raw),
    .i_push_raw  (i_push_raw),
    .o_coin      (o_coin),
    .o_push      (o_push),
    .o_coin_level(o_coin_level),
    .o_push_level(o_push_level),
    .o_credit    (o_credit)
  );

  always #5 clk = ~clk;

  // Reference model: a level flips once the synchronised input has differed
  // from it for D+1 consecutive samples; the sync path is a 2-sample delay.
  bit qc[$];
  bit qp[$];
  int run[2];
  bit lvl[2];
  bit pul[2];
  int cred;

  function automatic void model_reset();
    qc.delete();
    qp.delete();
    for (int c = 0; c < 2; c++) begin
      run[c] = 0; lvl[c] = 0; pul[c] = 0;
    end
    cred = 0;
  endfunction

  function automatic void model_edge(input bit rc, input bit rp);
    bit s[2];
    s[0] = 0; s[1] = 0;
    if (pul[0] && !pul[1] && cred < 7) cred++;
    else if (pul[1] && !pul[0] && cred > 0) cred--;
    qc.push_back(rc);
    qp.push_back(rp);
    if (qc.size() > 2) s[0] = qc.pop_front();
    if (qp.size() > 2) s[1] = qp.pop_front();
    for (int c = 0; c < 2; c++) begin
      pul[c] = 0;
      if (s[c] != lvl[c]) begin
        run[c]++;
        if (run[c] == D + 1) begin
          lvl[c] = s[c];
          pul[c] = s[c];
          run[c] = 0;
        end
      end else begin
        run[c] = 0;
      end
    end
  endfunction

  function automatic bit exp_coin();
`ifdef TURNSTILE_COIN_CREDIT_EN
    return cred != 0;
`else
    return pul[0];
`endif
  endfunction

  function automatic int exp_credit();
`ifdef TURNSTILE_COIN_CREDIT_EN
    return cred;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".o_coin"},       o_coin,       exp_coin());
    chk({tag, ".o_push"},       o_push,       pul[1]);
    chk({tag, ".o_coin_level"}, o_coin_level, lvl[0]);
    chk({tag, ".o_push_level"}, o_push_level, lvl[1]);
    chk({tag, ".o_credit"},     o_credit,     exp_credit());
  endtask

  // one rising edge; inputs are changed by callers 1 time unit after it
  task automatic step(input string tag);
    @(posedge clk);
    if (!i_reset) model_reset();
    else model_edge(i_coin_raw, i_push_raw);
    #1;
    chk_model(tag);
  endtask

  task automatic do_reset(input int cycles);
    i_reset = 1'b0;
    model_reset();
    #1;
    chk("rst_async.o_coin_level", o_coin_level, 1'b0);
    chk("rst_async.o_coin", o_coin, 1'b0);
    repeat (cycles) step("rst");
    i_reset = 1'b1;
  endtask

  task automatic press(input bit coin, input int n);
    for (int i = 0; i < n; i++) begin
      i_coin_raw = coin; i_push_raw = !coin;
      repeat (10) step("press_hi");
      i_coin_raw = 0; i_push_raw = 0;
      repeat (10) step("press_lo");
    end
  endtask

  typedef struct {
    bit rst; bit c; bit p;
    bit ec; bit ep; bit ecl; bit epl;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input bit rst, input bit c, input bit p,
                              input bit ec, input bit ep, input bit ecl, input bit epl);
    vec_t v;
    v.rst = rst; v.c = c; v.p = p; v.ec = ec; v.ep = ep; v.ecl = ecl; v.epl = epl;
    tbl.push_back(v);
  endfunction

  initial begin
    bit pb[13];
    pb = '{1, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};

    // coin held: pulse exactly 6 edges after first sampling edge, once
    for (int i = 0; i < 9; i++) add(i == 0, 1, 0, i == 6, 0, i >= 6, 0);
    // push bounces, final rise at entry 4 -> pulse at entry 10
    for (int i = 0; i < 13; i++) add(i == 0, 0, pb[i], 0, i == 10, 0, i >= 10);
    // both rise together
    for (int i = 0; i < 9; i++) add(i == 0, 1, 1, i == 6, i == 6, i >= 6, i >= 6);

    i_reset = 1'b0; i_coin_raw = 0; i_push_raw = 0;
    model_reset();
    #2;
    repeat (5) step("init_rst");
    i_reset = 1'b1;
    repeat (10) step("idle");

    foreach (tbl[k]) begin
      if (tbl[k].rst) begin
        i_coin_raw = 0; i_push_raw = 0;
        do_reset(2);
      end
      i_coin_raw = tbl[k].c;
      i_push_raw = tbl[k].p;
      step("tbl");
`ifndef TURNSTILE_COIN_CREDIT_EN
      chk($sformatf("tbl[%0d].o_coin", k), o_coin, tbl[k].ec);
`endif
      chk($sformatf("tbl[%0d].o_push", k), o_push, tbl[k].ep);
      chk($sformatf("tbl[%0d].o_coin_level", k), o_coin_level, tbl[k].ecl);
      chk($sformatf("tbl[%0d].o_push_level", k), o_push_level, tbl[k].epl);
      chk($sformatf("tbl[%0d].o_credit", k), o_credit, 3'd0);
    end

    // reset in the middle of the rise debounce abandons it
    i_coin_raw = 0; i_push_raw = 0;
    do_reset(2);
    i_coin_raw = 1;
    repeat (4) step("abort_pre");
    i_reset = 1'b0;
    model_reset();
    #1;
    chk("abort.o_coin_level", o_coin_level, 1'b0);
    chk("abort.o_coin", o_coin, 1'b0);
    step("abort_rst");
    i_reset = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step("abort_post");
`ifndef TURNSTILE_COIN_CREDIT_EN
      chk($sformatf("abort[%0d].o_coin", i), o_coin, (i == 6));
`endif
      chk($sformatf("abort[%0d].o_coin_level", i), o_coin_level, (i >= 6));
    end

`ifdef TURNSTILE_COIN_CREDIT_EN
    i_coin_raw = 0; i_push_raw = 0;
    do_reset(2);
    for (int i = 1; i <= 9; i++) begin
      press(1, 1);
      chk($sformatf("credit_up[%0d]", i), o_credit, (i > 7) ? 7 : i);
      chk($sformatf("credit_up[%0d].o_coin", i), o_coin, 1'b1);
    end
    for (int i = 1; i <= 8; i++) begin
      press(0, 1);
      chk($sformatf("credit_dn[%0d]", i), o_credit, (i > 7) ? 0 : 7 - i);
      chk($sformatf("credit_dn[%0d].o_coin", i), o_coin, (i < 7));
    end
`endif

    // random toggling with occasional resets
    i_coin_raw = 0; i_push_raw = 0;
    do_reset(2);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) i_coin_raw = !i_coin_raw;
      if ($urandom_range(0, 5) == 0) i_push_raw = !i_push_raw;
      if ($urandom_range(0, 599) == 0) begin
        do_reset($urandom_range(1, 3));
      end
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
